// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: mdu_op encodings and default latencies.
// Also used by the EX-stage decoder that drives mdu_op.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_MADD  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
        return n ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_timer.sv
// Loadable down-counter: busy stays high for load_val cycles after the load edge,
// done marks the final busy cycle (the edge on which results commit).
module mdu_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         busy,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (load) begin
            cnt  <= load_val;
            busy <= (load_val != '0);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
            if (cnt == W'(1))
                busy <= 1'b0;
        end
    end

    assign done = busy && (cnt == W'(1));

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit with architectural HI/LO.
// Optional accumulate (mdu_op=MADD) is built only when MDU_MADD_EN is defined.
//
// state | meaning
// IDLE  | accepts start; MTHI/MTLO write immediately, long ops stage a result
// RUN   | timer counting down; staged result commits on the done edge
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_e;

    state_e        state;
    mdu_op_e       op;
    logic [31:0]   stg_hi, stg_lo;
    logic          stg_wr;
    logic [31:0]   res_hi, res_lo;
    logic          res_wr, long_op, done, t_load;
    logic [CW-1:0] lat;

    assign op = mdu_op_e'(mdu_op);

    logic [63:0] prod_s, prod_u;
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide on magnitudes so the 0x80000000 / -1 case wraps cleanly.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_safe_s, b_safe_u, uq_s, ur_s;
    assign a_neg    = A[31];
    assign b_neg    = B[31];
    assign a_mag    = neg_if(A, a_neg);
    assign b_mag    = neg_if(B, b_neg);
    assign b_safe_s = (B == 32'd0) ? 32'd1 : b_mag;
    assign b_safe_u = (B == 32'd0) ? 32'd1 : B;
    assign uq_s     = a_mag / b_safe_s;
    assign ur_s     = a_mag % b_safe_s;

`ifdef MDU_MADD_EN
    logic [63:0] madd_sum;
    assign madd_sum = {HI, LO} + prod_s;
`endif

    always_comb begin
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        res_wr  = 1'b1;
        long_op = 1'b0;
        lat     = CW'(MULT_CYCLES);
        case (op)
            MDU_MULT: begin
                {res_hi, res_lo} = prod_s;
                long_op = 1'b1;
            end
            MDU_MULTU: begin
                {res_hi, res_lo} = prod_u;
                long_op = 1'b1;
            end
            MDU_DIV: begin
                res_lo  = neg_if(uq_s, a_neg ^ b_neg);
                res_hi  = neg_if(ur_s, a_neg);
                res_wr  = (B != 32'd0);
                long_op = 1'b1;
                lat     = CW'(DIV_CYCLES);
            end
            MDU_DIVU: begin
                res_lo  = A / b_safe_u;
                res_hi  = A % b_safe_u;
                res_wr  = (B != 32'd0);
                long_op = 1'b1;
                lat     = CW'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            MDU_MADD: begin
                {res_hi, res_lo} = madd_sum;
                long_op = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign t_load = (state == IDLE) && start && long_op;

    mdu_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .load_val (lat),
        .busy     (busy),
        .done     (done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            HI     <= 32'd0;
            LO     <= 32'd0;
            stg_hi <= 32'd0;
            stg_lo <= 32'd0;
            stg_wr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (long_op) begin
                            stg_hi <= res_hi;
                            stg_lo <= res_lo;
                            stg_wr <= res_wr;
                            state  <= RUN;
                        end else if (op == MDU_MTHI) begin
                            HI <= A;
                        end else if (op == MDU_MTLO) begin
                            LO <= A;
                        end
                    end
                end
                RUN: begin
                    if (done) begin
                        if (stg_wr) begin
                            HI <= stg_hi;
                            LO <= stg_lo;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: latency, signed/unsigned results, divide-by-zero,
// start during RUN, reset mid-operation and MADD (with or without MDU_MADD_EN).
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd0;
    logic [31:0] a_in = 32'd0;
    logic [31:0] b_in = 32'd0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_chk  = 0;
    int n_pass = 0;
    int n;

    always #5 clk = ~clk;

    mdu_iter dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .A      (a_in),
        .B      (b_in),
        .busy   (busy),
        .HI     (hi),
        .LO     (lo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        a_in   = a;
        b_in   = b;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts busy cycles (bounded); optionally pulses a MULT start on busy cycle 3.
    task automatic wait_busy(output int cnt, input bit inject);
        cnt = 0;
        while (busy && cnt < 50) begin
            cnt++;
            if (inject && cnt == 3) begin
                start  = 1'b1;
                mdu_op = 3'd0;
                a_in   = 32'd3;
                b_in   = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b0;

        // MULT -2 * 3
        issue(3'd0, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_hold", hi, 32'd0);
        wait_busy(n, 1'b0);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU 0xFFFFFFFF * 2
        issue(3'd1, 32'hFFFF_FFFF, 32'd2);
        wait_busy(n, 1'b0);
        chk("multu_cycles", 32'(n), 32'd5);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);

        // DIV -7 / 2
        issue(3'd2, 32'hFFFF_FFF9, 32'd2);
        wait_busy(n, 1'b0);
        chk("div_cycles", 32'(n), 32'd10);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIV 7 / -2
        issue(3'd2, 32'd7, 32'hFFFF_FFFE);
        wait_busy(n, 1'b0);
        chk("div2_lo", lo, 32'hFFFF_FFFD);
        chk("div2_hi", hi, 32'd1);

        // DIV overflow case
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy(n, 1'b0);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);

        // DIVU 0xFFFFFFFF / 16
        issue(3'd3, 32'hFFFF_FFFF, 32'd16);
        wait_busy(n, 1'b0);
        chk("divu_cycles", 32'(n), 32'd10);
        chk("divu_lo", lo, 32'h0FFF_FFFF);
        chk("divu_hi", hi, 32'h0000_000F);

        // MTHI / MTLO, then DIVU by zero with a MULT start during RUN
        issue(3'd4, 32'h11, 32'd0);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        chk("mthi_hi", hi, 32'h11);
        issue(3'd5, 32'h22, 32'd0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_lo", lo, 32'h22);
        issue(3'd3, 32'd5, 32'd0);
        wait_busy(n, 1'b1);
        chk("div0_cycles", 32'(n), 32'd10);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);
        repeat (2) @(negedge clk);
        chk("noqueue_busy", {31'd0, busy}, 32'd0);
        chk("noqueue_lo", lo, 32'h22);

        // Reset on busy cycle 4 of a DIV
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        chk("rstmid_busy4", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("rstmid_late_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_late_hi", hi, 32'd0);
        chk("rstmid_late_lo", lo, 32'd0);

        // Reserved op and MADD
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'hFFFF_FFFF, 32'd0);
        issue(3'd7, 32'd5, 32'd5);
        chk("rsvd_busy", {31'd0, busy}, 32'd0);
        chk("rsvd_hi", hi, 32'd0);
        chk("rsvd_lo", lo, 32'hFFFF_FFFF);
        issue(3'd6, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_busy(n, 1'b0);
        chk("madd_cycles", 32'(n), 32'd5);
        chk("madd_hi", hi, 32'd1);
        chk("madd_lo", lo, 32'd0);
`else
        chk("madd_off_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);
        chk("madd_off_hi", hi, 32'd0);
        chk("madd_off_lo", lo, 32'hFFFF_FFFF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Accepts a one-cycle start strobe with operands and holds busy for a fixed latency.
- Commits results to architectural HI/LO registers.
- Pipeline control stalls on busy or start.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU.
- DIV_CYCLES, 10, busy cycles for DIV/DIVU.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request strobe; sampled only when busy=0.
- mdu_op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6=MADD 7=reserved (no-op).
- A  input  32  rs operand.
- B  input  32  rt operand.
- busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset (synchronous, active-high): busy=0, HI=0, LO=0, counter=0, staged results cleared.
- Reset mid-operation aborts the operation; HI/LO still go to 0.
- States: IDLE, RUN.
- IDLE, start=1, mdu_op in {0,1,2,3,6}:
  - compute result combinationally from A/B and latch it into staging registers;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN; busy=1 from the next cycle.
- IDLE, start=1, mdu_op=4/5: HI<=A or LO<=A at that edge; busy stays 0.
- IDLE, start=1, mdu_op=7: ignored.
- RUN:
  - counter decrements each cycle.
  - On the cycle counter reaches 1, HI/LO take the staged values at that edge; busy=0 the following cycle; state returns to IDLE.
  - busy is high for exactly N cycles after the start cycle.
  - start is ignored (no queueing, no error); the issuing stage must stall.
- HI/LO hold their old values throughout RUN; they are visible only after busy falls.
- MULT: {HI,LO} = signed A × signed B, 64-bit.
- MULTU: {HI,LO} = unsigned A × unsigned B, 64-bit.
- DIV: LO = signed quotient, truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Division by zero (B=0): full DIV_CYCLES busy, then HI/LO unchanged.
- DIV with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.

Optional Feature:
- MDU_MADD_EN defined:
  - mdu_op=6 (MADD): {HI,LO} <= {HI,LO} + signed A × signed B, with MULT_CYCLES latency.
  - The accumulate uses HI/LO as sampled at start; 64-bit wrap-around on overflow.
- MDU_MADD_EN undefined: mdu_op=6 is treated as reserved (ignored, busy stays 0).

Decomposition:
- Package mdu_pkg:
  - mdu_op encodings (MDU_MULT … MDU_MADD);
  - default latency constants.
  - The decoder that drives mdu_op shares this package.
- Sub-module mdu_timer: loadable down-counter producing busy and a done pulse.
- Arithmetic stays in mdu_iter.

Test Plan:
1. Multiply latency: MULT A=0xFFFFFFFE (-2), B=3, start 1 cycle.
   - busy=1 for 5 cycles.
   - Then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
2. Unsigned multiply: MULTU A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE after 5 cycles.
3. Signed divide, negative dividend: DIV A=-7, B=2.
   - 10 busy cycles.
   - Then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
4. Divide by zero and start during RUN:
   - Preload HI=0x11, LO=0x22 via MTHI/MTLO (busy stays 0).
   - DIVU A=5, B=0 -> busy 10 cycles, HI/LO still 0x11/0x22.
   - A MULT start mid-RUN is ignored.
5. Reset mid-operation: DIV in flight, reset asserted at busy cycle 4 -> next cycle busy=0, HI=0, LO=0; no late commit afterwards.
6. MADD (MDU_MADD_EN): HI=0, LO=0xFFFFFFFF, MADD A=1, B=1 -> HI=1, LO=0 after 5 cycles.
   - Without the macro, the same stimulus leaves busy=0 and HI/LO unchanged.
